// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_ctrl
// Purpose  : Four-digit multiplexed seven-segment scan controller. A
//            prescaler paces a 2-bit digit counter. A 16-bit shadow
//            register is reloaded only at frame end, so the display never
//            tears. Reloads use a req/ack handshake.
// Options  : SEG_LEADING_ZERO_BLANK_EN - blank leading zero digits 3..1
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        disp_en,
  input  logic        upd_req,
  input  logic [15:0] upd_data,
  output logic        upd_ack,
  output logic [1:0]  sel_o,
  output logic [3:0]  bcd_o,
  output logic        blank_o
);

  localparam logic [19:0] c_presc_last = 20'(REFRESH_DIV - 1);

  logic [19:0] r_presc;
  logic [1:0]  r_digit;
  logic [15:0] r_shadow;
  logic        r_ack;
  logic        w_tick;
  logic        w_frame_end;
  logic        w_lz_blank;

  assign w_tick      = (r_presc == c_presc_last);
  assign w_frame_end = w_tick && (r_digit == 2'd3);

  // Prescaler: free-running 0..REFRESH_DIV-1, one tick per digit slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= 20'd0;
    end else if (w_tick) begin
      r_presc <= 20'd0;
    end else begin
      r_presc <= r_presc + 20'd1;
    end
  end

  // Digit counter advances once per tick and wraps naturally from 3 to 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_digit <= 2'd0;
    end else if (w_tick) begin
      r_digit <= r_digit + 2'd1;
    end
  end

  // Shadow reload and ack pulse only at frame end, so a frame never tears
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= 16'h0000;
      r_ack    <= 1'b0;
    end else begin
      r_ack <= w_frame_end && upd_req;
      if (w_frame_end && upd_req) begin
        r_shadow <= upd_data;
      end
    end
  end

  // Select the shadow nibble addressed by the current digit
  always_comb begin
    bcd_o = r_shadow[3:0];
    case (r_digit)
      2'd0: bcd_o = r_shadow[3:0];
      2'd1: bcd_o = r_shadow[7:4];
      2'd2: bcd_o = r_shadow[11:8];
      2'd3: bcd_o = r_shadow[15:12];
      default: bcd_o = r_shadow[3:0];
    endcase
  end

`ifdef SEG_LEADING_ZERO_BLANK_EN
  // Digit k is dark when it and every digit to its left are zero; digit 0 always shows
  always_comb begin
    w_lz_blank = 1'b0;
    case (r_digit)
      2'd3: w_lz_blank = (r_shadow[15:12] == 4'h0);
      2'd2: w_lz_blank = (r_shadow[15:8]  == 8'h00);
      2'd1: w_lz_blank = (r_shadow[15:4]  == 12'h000);
      default: w_lz_blank = 1'b0;
    endcase
  end
`else
  // All four digits show, zeros included
  always_comb begin
    w_lz_blank = 1'b0;
  end
`endif

  assign sel_o   = r_digit;
  assign upd_ack = r_ack;
  assign blank_o = !disp_en || w_lz_blank;

endmodule
`default_nettype wire
